// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: address generator and control for a KxK sliding-window convolution over an
// IMG_W x IMG_H image held in a ROM with ROM_LAT cycles of read latency.
//
// The block walks the window origin in raster order over every valid position. Each cycle it
// presents the K*K tap addresses of one window. It delays the issue strobe to mark when ROM data
// reaches the MAC (mac_en) and when the result register is valid (out_valid). Each result carries
// its raster index (out_addr).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        one-cycle request to scan the whole image; ignored unless idle
//   hold         pause: no window is issued while high, and the window does not advance
//   win_addr     packed tap addresses, tap k = r*K + c at [ADDR_W*k +: ADDR_W]
//   issue_valid  win_addr carries a new window this cycle
//   mac_en       ROM data for an issued window is present
//   out_valid    datapath result register holds a valid output pixel
//   out_addr     raster index of the current output pixel
//   busy         scan in progress (RUN, DRAIN, DONE)
//   done         one-cycle pulse the cycle after the last out_valid
//
// IMG_W*IMG_H-1 must fit in ADDR_W bits; all address arithmetic wraps at ADDR_W bits.

module conv_scan_ctrl #(
  parameter int unsigned IMG_W   = 28,
  parameter int unsigned IMG_H   = 28,
  parameter int unsigned K       = 3,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    hold,
  output logic [K*K*ADDR_W-1:0]   win_addr,
  output logic                    issue_valid,
  output logic                    mac_en,
  output logic                    out_valid,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] ColLast = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] RowLast = ADDR_W'(IMG_H - K);
  localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);
  // Moving from the last column of one row to column 0 of the next skips K-1 pixels,
  // so the step is K, not 1.
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(K);

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   row_q;
  logic [ADDR_W-1:0]   col_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                busy_q;
  logic                done_q;

  // pipe_q[i] is issue_valid delayed by i+1 cycles.
  logic [ROM_LAT:0]    pipe_q;
  logic [ROM_LAT:0]    pipe_d;

  logic                last_win;

  assign last_win    = (row_q == RowLast) && (col_q == ColLast);
  // Combinational so that hold suppresses the issue in the very cycle it is asserted.
  assign issue_valid = (state_q == StRun) && !hold;

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = issue_valid;
    for (int i = 1; i <= int'(ROM_LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  generate
    if (ROM_LAT == 0) begin : g_mac_direct
      assign mac_en = issue_valid;
    end else begin : g_mac_pipe
      assign mac_en = pipe_q[ROM_LAT-1];
    end
  endgenerate

  assign out_valid = pipe_q[ROM_LAT];
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    win_addr = '0;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K); c++) begin
        win_addr[ADDR_W*(r*int'(K)+c) +: ADDR_W] = base_q + ADDR_W'(r*int'(IMG_W) + c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      out_addr_q <= '0;
      pipe_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // The delay line runs in every state so in-flight windows drain through hold and DRAIN.
      pipe_q <= pipe_d;
      done_q <= 1'b0;
      if (out_valid) begin
        out_addr_q <= out_addr_q + One;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            busy_q     <= 1'b1;
            base_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            out_addr_q <= '0;
          end
        end

        StRun: begin
          if (issue_valid) begin
            if (last_win) begin
              // Park the origin at 0 so idle taps show the first window again.
              state_q <= StDrain;
              base_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
            end else if (col_q < ColLast) begin
              col_q  <= col_q + One;
              base_q <= base_q + One;
            end else begin
              col_q  <= '0;
              row_q  <= row_q + One;
              base_q <= base_q + RowStep;
            end
          end
        end

        StDrain: begin
          // Leave once nothing valid remains for the next cycle. The final out_valid is then
          // followed directly by the done cycle.
          if (pipe_d == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed testbench for conv_scan_ctrl with default parameters (28x28 image, K=3, ROM_LAT=1).
module tb_conv_scan_ctrl;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int K       = 3;
  localparam int ADDR_W  = 10;
  localparam int ROM_LAT = 1;
  localparam int NWIN    = (IMG_W - K + 1) * (IMG_H - K + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  hold = 1'b0;
  logic [K*K*ADDR_W-1:0] win_addr;
  logic                  issue_valid;
  logic                  mac_en;
  logic                  out_valid;
  logic [ADDR_W-1:0]     out_addr;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  conv_scan_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .ADDR_W (ADDR_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hold       (hold),
    .win_addr   (win_addr),
    .issue_valid(issue_valid),
    .mac_en     (mac_en),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;

  // Observation record, written only by tick() and clear_stats().
  int cyc = 0;
  int n_issue, issue_gaps, last_issue, first_issue, first_mac, first_out;
  int n_out, addr_err, last_out, first_out_addr, last_out_addr;
  int n_done, done_cyc, n_busy;
  int hold_cycles, hold_iv, hold_outs, hold_frz, hold_tap0;
  int scan_start;
  logic [K*K*ADDR_W-1:0] first_win, hold_win, exp_win0;
  int bases [0:1023];
  int last_tap8;

  task automatic clear_stats();
    n_issue = 0; issue_gaps = 0; last_issue = -1; first_issue = -1; first_mac = -1;
    first_out = -1; n_out = 0; addr_err = 0; last_out = -1; first_out_addr = -1;
    last_out_addr = -1; n_done = 0; done_cyc = -1; n_busy = 0;
    hold_cycles = 0; hold_iv = 0; hold_outs = 0; hold_frz = 0; hold_tap0 = -1;
    first_win = '0; hold_win = '0; last_tap8 = -1;
  endtask

  // Called at posedge+1 with inputs already set for this cycle; samples at the negedge and
  // returns at posedge+1 of the next cycle.
  task automatic tick();
    @(negedge clk);
    if (issue_valid) begin
      if (n_issue == 0) begin
        first_issue = cyc;
        first_win   = win_addr;
      end else if (cyc != last_issue + 1) begin
        issue_gaps++;
      end
      last_issue = cyc;
      if (n_issue < 1024) bases[n_issue] = int'(win_addr[ADDR_W-1:0]);
      last_tap8 = int'(win_addr[ADDR_W*8 +: ADDR_W]);
      n_issue++;
    end
    if (mac_en && first_mac < 0) first_mac = cyc;
    if (out_valid) begin
      if (first_out < 0) begin
        first_out      = cyc;
        first_out_addr = int'(out_addr);
      end
      if (int'(out_addr) != n_out) addr_err++;
      last_out_addr = int'(out_addr);
      last_out = cyc;
      n_out++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) n_busy++;
    if (hold && busy) begin
      hold_cycles++;
      if (issue_valid) hold_iv++;
      if (out_valid) hold_outs++;
      if (hold_cycles == 1) hold_tap0 = int'(win_addr[ADDR_W-1:0]);
      else if (win_addr !== hold_win) hold_frz++;
      hold_win = win_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulses start and runs until done. Holds for hold_len cycles when hold_at windows have
  // issued, re-pulses start at start_at, and drops rst (returning at once) at abort_at.
  task automatic run_scan(input int hold_at, input int hold_len, input int start_at,
                          input int abort_at, output bit to);
    int held = 0;
    bit restarted = 1'b0;
    int budget = 0;
    to = 1'b0;
    clear_stats();
    scan_start = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (n_done == 0) begin
      if (budget > 3000) begin
        to = 1'b1;
        break;
      end
      if (n_issue == abort_at) begin
        rst = 1'b0;
        break;
      end
      hold = (n_issue == hold_at) && (held < hold_len);
      if (hold) held++;
      start = (n_issue == start_at) && !restarted;
      if (start) restarted = 1'b1;
      tick();
      budget++;
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    int busy_seen = 0;
    @(posedge clk);
    #1;
    if ({issue_valid, mac_en, out_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {issue_valid, mac_en, out_valid, busy, done});
    end
    checks++;
    if (out_addr !== '0) begin
      errors++;
      $display("FAIL reset_out_addr: got %0d expected 0", out_addr);
    end
    checks++;
    if (win_addr !== exp_win0) begin
      errors++;
      $display("FAIL reset_win_addr: got %h expected %h", win_addr, exp_win0);
    end
    checks++;
    if (win_addr[ADDR_W*8 +: ADDR_W] !== 10'd58) begin
      errors++;
      $display("FAIL reset_tap8: got %0d expected 58", win_addr[ADDR_W*8 +: ADDR_W]);
    end
    checks++;
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (busy || issue_valid) busy_seen++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy_seen !== 0) begin
      errors++;
      $display("FAIL idle_no_busy: got %0d busy cycles expected 0", busy_seen);
    end
    checks++;
  endtask

  task automatic test_full_scan();
    bit to;
    run_scan(-1, 0, -1, -1, to);
    if (to !== 1'b0) begin errors++; $display("FAIL full_timeout: got 1 expected 0"); end
    checks++;
    if (n_issue !== NWIN) begin
      errors++; $display("FAIL full_issue_count: got %0d expected %0d", n_issue, NWIN);
    end
    checks++;
    if (issue_gaps !== 0) begin
      errors++; $display("FAIL full_issue_consecutive: got %0d gaps expected 0", issue_gaps);
    end
    checks++;
    if (first_win !== exp_win0) begin
      errors++; $display("FAIL full_first_taps: got %h expected %h", first_win, exp_win0);
    end
    checks++;
    if (bases[25] !== 25) begin
      errors++; $display("FAIL full_base_26th: got %0d expected 25", bases[25]);
    end
    checks++;
    if (bases[26] !== 28) begin
      errors++; $display("FAIL full_base_27th: got %0d expected 28", bases[26]);
    end
    checks++;
    if (bases[NWIN-1] !== 725) begin
      errors++; $display("FAIL full_base_last: got %0d expected 725", bases[NWIN-1]);
    end
    checks++;
    if (last_tap8 !== 783) begin
      errors++; $display("FAIL full_last_tap8: got %0d expected 783", last_tap8);
    end
    checks++;
    if (n_out !== NWIN || addr_err !== 0 || last_out_addr !== NWIN - 1) begin
      errors++;
      $display("FAIL full_out_addr: got n=%0d err=%0d last=%0d expected n=%0d err=0 last=%0d",
               n_out, addr_err, last_out_addr, NWIN, NWIN - 1);
    end
    checks++;
    if (n_done !== 1 || done_cyc !== last_out + 1) begin
      errors++;
      $display("FAIL full_done: got n=%0d at %0d expected n=1 at %0d",
               n_done, done_cyc, last_out + 1);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL full_idle_after: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
  endtask

  task automatic test_latency();
    bit to;
    run_scan(-1, 0, -1, -1, to);
    if (first_issue !== scan_start + 1) begin
      errors++;
      $display("FAIL lat_issue: got %0d expected %0d", first_issue, scan_start + 1);
    end
    checks++;
    if (first_mac !== scan_start + 2) begin
      errors++;
      $display("FAIL lat_mac_en: got %0d expected %0d", first_mac, scan_start + 2);
    end
    checks++;
    if (first_out !== scan_start + 3) begin
      errors++;
      $display("FAIL lat_out_valid: got %0d expected %0d", first_out, scan_start + 3);
    end
    checks++;
  endtask

  task automatic test_hold();
    bit to;
    // Window 40 is row 1, col 14: base 28 + 14 = 42.
    run_scan(40, 5, -1, -1, to);
    if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout: got 1 expected 0"); end
    checks++;
    if (hold_cycles !== 5 || hold_iv !== 0) begin
      errors++;
      $display("FAIL hold_no_issue: got cycles=%0d issues=%0d expected 5 0",
               hold_cycles, hold_iv);
    end
    checks++;
    if (hold_frz !== 0 || hold_tap0 !== 42) begin
      errors++;
      $display("FAIL hold_frozen: got changes=%0d tap0=%0d expected 0 42", hold_frz, hold_tap0);
    end
    checks++;
    if (hold_outs !== 2) begin
      errors++; $display("FAIL hold_inflight: got %0d outputs expected 2", hold_outs);
    end
    checks++;
    if (n_issue !== NWIN || n_out !== NWIN || addr_err !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL hold_totals: got iss=%0d out=%0d err=%0d done=%0d expected %0d %0d 0 1",
               n_issue, n_out, addr_err, n_done, NWIN, NWIN);
    end
    checks++;
  endtask

  task automatic test_final_hold();
    bit to;
    run_scan(NWIN - 1, 3, -1, -1, to);
    if (hold_cycles !== 3 || hold_iv !== 0 || hold_tap0 !== 725) begin
      errors++;
      $display("FAIL final_hold: got cycles=%0d issues=%0d tap0=%0d expected 3 0 725",
               hold_cycles, hold_iv, hold_tap0);
    end
    checks++;
    if (n_issue !== NWIN || bases[NWIN-1] !== 725 || last_tap8 !== 783) begin
      errors++;
      $display("FAIL final_hold_issue: got n=%0d base=%0d tap8=%0d expected %0d 725 783",
               n_issue, bases[NWIN-1], last_tap8, NWIN);
    end
    checks++;
    if (n_done !== 1 || done_cyc !== last_out + 1 || n_out !== NWIN) begin
      errors++;
      $display("FAIL final_hold_done: got done=%0d at %0d outs=%0d expected 1 at %0d %0d",
               n_done, done_cyc, n_out, last_out + 1, NWIN);
    end
    checks++;
  endtask

  task automatic test_start_while_busy();
    bit to;
    run_scan(-1, 0, 100, -1, to);
    if (to !== 1'b0) begin errors++; $display("FAIL restart_timeout: got 1 expected 0"); end
    checks++;
    if (n_issue !== NWIN || issue_gaps !== 0) begin
      errors++;
      $display("FAIL restart_issues: got n=%0d gaps=%0d expected %0d 0",
               n_issue, issue_gaps, NWIN);
    end
    checks++;
    if (n_out !== NWIN || addr_err !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL restart_outputs: got out=%0d err=%0d done=%0d expected %0d 0 1",
               n_out, addr_err, n_done, NWIN);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    bit to;
    run_scan(-1, 0, -1, 300, to);
    #1;
    if ({issue_valid, mac_en, out_valid, busy, done} !== 5'b0 || win_addr !== exp_win0) begin
      errors++;
      $display("FAIL abort_immediate: got %b win=%h expected 00000 win=%h",
               {issue_valid, mac_en, out_valid, busy, done}, win_addr, exp_win0);
    end
    checks++;
    @(posedge clk);
    #1;
    cyc++;
    clear_stats();
    tick();
    rst = 1'b1;
    repeat (10) tick();
    if (n_done !== 0 || n_busy !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got done=%0d busy=%0d expected 0 0", n_done, n_busy);
    end
    checks++;
    run_scan(-1, 0, -1, -1, to);
    if (bases[0] !== 0 || first_out_addr !== 0) begin
      errors++;
      $display("FAIL abort_fresh_start: got base=%0d out_addr=%0d expected 0 0",
               bases[0], first_out_addr);
    end
    checks++;
    if (n_out !== NWIN || addr_err !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL abort_rescan: got out=%0d err=%0d done=%0d expected %0d 0 1",
               n_out, addr_err, n_done, NWIN);
    end
    checks++;
  endtask

  initial begin
    int taps [9];
    taps = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    for (int k = 0; k < 9; k++) exp_win0[ADDR_W*k +: ADDR_W] = ADDR_W'(taps[k]);
    clear_stats();
    test_reset();
    test_full_scan();
    test_latency();
    test_hold();
    test_final_hold();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_scan_ctrl.md
CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

Interface
REQ-001 Parameters (name, default, meaning); all SHALL be honoured:
- IMG_W, 28, input image width in pixels
- IMG_H, 28, input image height in pixels
- K, 3, square kernel size
- ADDR_W, 10, pixel address width
- ROM_LAT, 1, image ROM read latency in cycles
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock, rising edge
- rst, in, 1, reset; asynchronous, active-low
- start, in, 1, one-cycle request to begin a full-image scan
- hold, in, 1, pause request; while high, no new window is issued
- win_addr, out, K*K*ADDR_W, packed tap addresses; tap k=r*K+c occupies bits [ADDR_W*k+ADDR_W-1 : ADDR_W*k]
- issue_valid, out, 1, win_addr holds a new window this cycle
- mac_en, out, 1, ROM data for an issued window is present; the datapath latches its products/sum
- out_valid, out, 1, the datapath result register holds a valid output pixel
- out_addr, out, ADDR_W, raster index of that output pixel, 0..(IMG_W-K+1)*(IMG_H-K+1)-1
- busy, out, 1, high from the cycle after start is accepted until done
- done, out, 1, one-cycle pulse after the last out_valid

Function
REQ-003 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE -> RUN when start=1; start SHALL be ignored in every other state.
REQ-005 RUN: on each cycle with hold=0, the block SHALL assert issue_valid with the current window and then advance it; with hold=1, issue_valid=0 and the window SHALL not change.
REQ-006 Window origin base SHALL start at 0, with tap address base + r*IMG_W + c.
REQ-007 Advance: if col < IMG_W-K then col+1 and base+1; otherwise col=0, row+1, base+K.
REQ-008 Issuing the window at row=IMG_H-K, col=IMG_W-K SHALL cause RUN -> DRAIN on the next cycle.
REQ-009 mac_en SHALL equal issue_valid delayed exactly ROM_LAT cycles; out_valid SHALL equal issue_valid delayed ROM_LAT+1 cycles. The delay pipeline SHALL keep running during hold and DRAIN.
REQ-010 out_addr SHALL start at 0 per scan and increment by 1 after each out_valid cycle, never wrapping within a scan.
REQ-011 DRAIN -> DONE when the delay pipeline holds no valid entry and out_valid=0 that cycle; DONE lasts one cycle with done=1, then -> IDLE.
REQ-012 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-013 Latency: start sampled at edge T gives the first issue_valid in the cycle after T, and the first out_valid ROM_LAT+1 cycles later (hold=0).
REQ-014 A scan with hold=0 SHALL issue exactly (IMG_W-K+1)*(IMG_H-K+1) windows on consecutive cycles; the default is 676.
REQ-015 A hold asserted in the same cycle as the final window SHALL suppress that issue; the final window SHALL be issued on the first cycle with hold=0.
REQ-016 Address arithmetic SHALL be unsigned ADDR_W-bit. The maximum tap address IMG_W*IMG_H-1 SHALL fit in ADDR_W bits; the default is 783.

Reset
REQ-017 rst=0 SHALL immediately force:
- state=IDLE; base, row, col, out_addr = 0
- delay pipeline cleared
- issue_valid, mac_en, out_valid, busy, done = 0
- win_addr taps = r*IMG_W + c
REQ-018 Reset during RUN or DRAIN SHALL abort the scan with no done pulse. The next start SHALL begin a fresh scan from base 0.

Verification
REQ-019 Idle reset: rst low -> all outputs 0; tap 8 = 58; start held 0 for 50 cycles -> busy stays 0.
REQ-020 Full scan, hold=0, defaults: start pulse ->
- 676 issue_valid cycles, consecutive
- first win_addr taps 0,1,2,28,29,30,56,57,58
- 26th window base 25; 27th base 28; last base 725, tap 8 = 783
- out_addr 0..675
- done one cycle after the last out_valid
REQ-021 Latency: start at cycle 0 -> issue_valid first at cycle 1, mac_en at 2, out_valid at 3 (ROM_LAT=1).
REQ-022 Hold: hold high for 5 cycles mid-row -> issue_valid=0 and win_addr frozen for those 5 cycles; in-flight out_valid entries still emerge; total outputs still 676 and out_addr stays gap-free.
REQ-023 Start while busy: a second start pulse at window 100 -> ignored; scan completes normally with 676 outputs.
REQ-024 Reset mid-scan: rst low at window 300 -> busy=0 and no done pulse; a new start -> first window base 0 and out_addr restarts at 0.
